memwb_skid_stage: RTL and testbench

- Parametrised MEM/WB pipeline stage, successor to the fixed MEM/WB register.
- Carries memory read data, ALU result, destination register and write-back controls from MEM to WB.
- Adds a valid/ready handshake with a one-entry skid buffer, flush, and global debug halt.
- Adds load byte/half extraction with sign/zero extension, and produces the final write-back data and write enable.

---
 rtl/memwb_skid_stage.sv | 193 +++++++++++++++++++
 tb/tb_memwb_skid_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage: MEM/WB pipeline stage with valid/ready handshake, a
// one-entry skid buffer, flush, debug halt and load byte/half/word
// extraction producing the final write-back data and write enable.
// Optional build macro MEMWB_PERF_CNT_EN adds stall and flush counters.
module memwb_skid_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_LANE = 2
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_reg_read,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_REG-1:0]  i_reg2write,
    input  logic               i_mem2reg,
    input  logic               i_regWrite,
    input  logic [1:0]         i_ld_size,
    input  logic               i_ld_unsigned,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic               o_regWrite,
    output logic               o_misaligned
`ifdef MEMWB_PERF_CNT_EN
    ,
    output logic [31:0]        o_stall_cnt,
    output logic [15:0]        o_flush_cnt
`endif
);

    typedef struct packed {
        logic [NB_DATA-1:0] reg_read;
        logic [NB_DATA-1:0] result;
        logic [NB_REG-1:0]  reg2write;
        logic               mem2reg;
        logic               regWrite;
        logic [1:0]         ld_size;
        logic               ld_unsigned;
    } entry_t;

    // Occupancy: FULL = main only, SKID = main and skid both held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_ent;

    logic main_valid, skid_valid, accept, emit;

    assign in_ent = '{reg_read: i_reg_read, result: i_result, reg2write: i_reg2write,
                      mem2reg: i_mem2reg, regWrite: i_regWrite, ld_size: i_ld_size,
                      ld_unsigned: i_ld_unsigned};

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == SKID);
    // Ready depends only on registered occupancy, never on i_ready.
    assign o_ready    = !skid_valid && !i_halt;
    assign accept     = i_valid && o_ready;
    assign emit       = main_valid && i_ready && !i_halt;

    // Next occupancy and payload; flush beats halt, halt freezes everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else if (!i_halt) begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_d  = in_ent;
                    state_d = FULL;
                end
                FULL: begin
                    if (accept && emit) begin
                        main_d = in_ent;
                    end else if (accept) begin
                        skid_d  = in_ent;
                        state_d = SKID;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                SKID: if (emit) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stage registers; reset also zeroes payload so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Bits at or above w take the fill value (sign or zero).
    function automatic logic [NB_DATA-1:0] extend(input logic [NB_DATA-1:0] v,
                                                  input int w, input logic fill);
        logic [NB_DATA-1:0] r;
        for (int i = 0; i < NB_DATA; i++) r[i] = (i < w) ? v[i] : fill;
        return r;
    endfunction

    logic [NB_LANE-1:0] lane, lane_h, lane_w;
    logic [NB_DATA-1:0] sh_b, sh_h, sh_w, ext;
    logic               mis;

    assign lane   = main_q.result[NB_LANE-1:0];
    assign lane_h = lane & ~NB_LANE'(1);
    assign lane_w = lane & ~NB_LANE'(3);
    assign sh_b   = main_q.reg_read >> {lane, 3'b000};
    assign sh_h   = main_q.reg_read >> {lane_h, 3'b000};
    assign sh_w   = main_q.reg_read >> {lane_w, 3'b000};

    // Little-endian load extraction and alignment check from the main entry.
    always_comb begin
        ext = main_q.reg_read;
        mis = 1'b0;
        case (main_q.ld_size)
            2'b00: ext = extend(sh_b, 8, !main_q.ld_unsigned && sh_b[7]);
            2'b01: begin
                ext = extend(sh_h, 16, !main_q.ld_unsigned && sh_h[15]);
                mis = lane[0];
            end
            default: begin
                if (NB_DATA == 64 && main_q.ld_size == 2'b11) begin
                    ext = main_q.reg_read;
                    mis = (lane != '0);
                end else begin
                    // On a 32-bit datapath this is the whole word.
                    ext = extend(sh_w, 32, !main_q.ld_unsigned && sh_w[31]);
                    mis = ((lane & NB_LANE'(3)) != '0);
                end
            end
        endcase
    end

    assign o_valid      = main_valid && !i_halt;
    assign o_misaligned = main_valid && main_q.mem2reg && mis;
    assign o_regWrite   = main_valid && main_q.regWrite && !o_misaligned && !i_halt;
    assign o_wb_data    = main_q.mem2reg ? ext : main_q.result;
    assign o_reg2write  = main_q.reg2write;

`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Counters freeze during halt; a flush counts only if it dropped a held entry.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!i_halt) begin
            if (o_valid && !i_ready) stall_cnt_d = stall_cnt_q + 32'd1;
            if (i_flush && main_valid) flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    // Counter registers, wrapping naturally.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// tb_memwb_skid_stage: directed plus random stimulus against a queue model
// of the stage (a two-deep FIFO with load extraction done arithmetically).
module tb_memwb_skid_stage;

    logic        clk = 1'b0;
    logic        rst, halt, flush, vld, rdy, m2r, rw, uns;
    logic [31:0] rr, res;
    logic [4:0]  rd;
    logic [1:0]  sz;
    logic        o_ready, o_valid, o_regWrite, o_misaligned;
    logic [31:0] o_wb_data;
    logic [4:0]  o_reg2write;
`ifdef MEMWB_PERF_CNT_EN
    logic [31:0] o_stall_cnt;
    logic [15:0] o_flush_cnt;
    int unsigned m_stall, m_flush;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memwb_skid_stage #(.NB_DATA(32), .NB_REG(5), .NB_LANE(2)) dut (
        .clk(clk), .i_reset(rst), .i_halt(halt), .i_flush(flush),
        .i_valid(vld), .o_ready(o_ready), .i_reg_read(rr), .i_result(res),
        .i_reg2write(rd), .i_mem2reg(m2r), .i_regWrite(rw), .i_ld_size(sz),
        .i_ld_unsigned(uns), .o_valid(o_valid), .i_ready(rdy),
        .o_wb_data(o_wb_data), .o_reg2write(o_reg2write),
        .o_regWrite(o_regWrite), .o_misaligned(o_misaligned)
`ifdef MEMWB_PERF_CNT_EN
        , .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] rr;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic [1:0]  sz;
        logic        uns;
    } ent_t;

    ent_t q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_mis(input ent_t e);
        int lane = int'(e.res[1:0]);
        if (e.sz == 2'd0) return 1'b0;
        if (e.sz == 2'd1) return (lane % 2) != 0;
        return lane != 0;
    endfunction

    function automatic logic [31:0] exp_data(input ent_t e);
        int lane = int'(e.res[1:0]);
        logic [31:0] v;
        if (!e.m2r) return e.res;
        if (e.sz == 2'd0) begin
            v = (e.rr >> (8 * lane)) & 32'hFF;
            if (!e.uns && v > 32'd127) v = v - 32'd256;
            return v;
        end
        if (e.sz == 2'd1) begin
            v = (e.rr >> (8 * (lane & 2))) & 32'hFFFF;
            if (!e.uns && v > 32'd32767) v = v - 32'd65536;
            return v;
        end
        return e.rr;
    endfunction

    task automatic check_outputs();
        bit   has, mis;
        ent_t h;
        has = q.size() > 0;
        if (has) h = q[0];
        mis = has && h.m2r && exp_mis(h);
        chk("ready", o_ready, (q.size() < 2) && !halt);
        chk("valid", o_valid, has && !halt);
        chk("misaligned", o_misaligned, mis);
        chk("regwrite", o_regWrite, has && h.rw && !mis && !halt);
        if (has) begin
            chk("reg2write", o_reg2write, h.rd);
            if (!mis) chk("wbdata", o_wb_data, exp_data(h));
        end
`ifdef MEMWB_PERF_CNT_EN
        chk("stall_cnt", o_stall_cnt, m_stall);
        chk("flush_cnt", o_flush_cnt, m_flush & 16'hFFFF);
`endif
    endtask

    // Model reaction to the coming clock edge using the current inputs.
    task automatic model_step();
        bit   acc, em;
        ent_t e;
        e = '{rr: rr, res: res, rd: rd, m2r: m2r, rw: rw, sz: sz, uns: uns};
        if (rst) begin
            q.delete();
`ifdef MEMWB_PERF_CNT_EN
            m_stall = 0; m_flush = 0;
`endif
            return;
        end
`ifdef MEMWB_PERF_CNT_EN
        if (!halt) begin
            if (q.size() > 0 && !rdy) m_stall++;
            if (flush && q.size() > 0) m_flush++;
        end
`endif
        if (flush) q.delete();
        else if (!halt) begin
            acc = vld && q.size() < 2;
            em  = q.size() > 0 && rdy;
            if (em) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [4:0] d, input logic [31:0] r,
                          input logic [31:0] mem, input bit lm, input logic [1:0] s,
                          input bit u);
        vld = v; rd = d; res = r; rr = mem; m2r = lm; sz = s; uns = u; rw = 1'b1;
    endtask

    initial begin
        rst = 1; halt = 0; flush = 0; rdy = 1;
        set_in(0, 0, 0, 0, 0, 0, 0);
`ifdef MEMWB_PERF_CNT_EN
        m_stall = 0; m_flush = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_wb", o_wb_data, 0);
        chk("rst_rd", o_reg2write, 0);
        chk("rst_rw", o_regWrite, 0);
        chk("rst_mis", o_misaligned, 0);
        rst = 0;

        // ALU result pass-through
        set_in(1, 7, 32'h0000_1234, 0, 0, 0, 0); cyc();
        chk("alu_valid", o_valid, 1);
        chk("alu_wb", o_wb_data, 32'h0000_1234);
        chk("alu_rd", o_reg2write, 7);
        chk("alu_rw", o_regWrite, 1);

        // Byte loads
        set_in(1, 1, 32'h2, 32'h80FF_7F01, 1, 0, 0); cyc();
        chk("ldb_s2", o_wb_data, 32'hFFFF_FFFF);
        set_in(1, 2, 32'h2, 32'h80FF_7F01, 1, 0, 1); cyc();
        chk("ldb_u2", o_wb_data, 32'h0000_00FF);
        set_in(1, 3, 32'h1, 32'h80FF_7F01, 1, 0, 0); cyc();
        chk("ldb_s1", o_wb_data, 32'h0000_007F);

        // Misaligned half
        set_in(1, 4, 32'h1, 32'h80FF_7F01, 1, 1, 0); cyc();
        chk("mis_flag", o_misaligned, 1);
        chk("mis_rw", o_regWrite, 0);
        chk("mis_valid", o_valid, 1);
        vld = 0; cyc();

        // Back-pressure into SKID then drain
        rdy = 0;
        set_in(1, 10, 32'h10, 0, 0, 0, 0); cyc();
        set_in(1, 11, 32'h11, 0, 0, 0, 0); cyc();
        chk("bp_ready", o_ready, 0);
        chk("bp_headA", o_reg2write, 10);
        vld = 0; rdy = 1; cyc();
        chk("bp_headB", o_reg2write, 11);
        chk("bp_validB", o_valid, 1);
        cyc();
        chk("bp_empty", o_valid, 0);
        chk("bp_ready1", o_ready, 1);

        // Flush in SKID together with an incoming entry
        rdy = 0;
        set_in(1, 12, 32'h12, 0, 0, 0, 0); cyc();
        set_in(1, 13, 32'h13, 0, 0, 0, 0); cyc();
        set_in(1, 20, 32'h20, 0, 0, 0, 0); flush = 1; cyc();
        flush = 0; vld = 0; #1;
        chk("fl_valid", o_valid, 0);
        chk("fl_ready", o_ready, 1);
        rdy = 1; cyc();
        chk("fl_gone", o_valid, 0);

        // Halt while FULL
        set_in(1, 21, 32'h21, 0, 0, 0, 0); cyc();
        vld = 0; halt = 1;
        repeat (3) begin
            cyc();
            chk("halt_valid", o_valid, 0);
            chk("halt_rw", o_regWrite, 0);
        end
        halt = 0; #1;
        chk("halt_rel_v", o_valid, 1);
        chk("halt_rel_rd", o_reg2write, 21);
        cyc();
        chk("halt_once", o_valid, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            vld   = ($urandom % 10) < 7;
            rdy   = ($urandom % 10) < 7;
            halt  = ($urandom % 10) == 0;
            flush = ($urandom % 20) == 0;
            rst   = ($urandom % 100) == 0;
            rd    = 5'($urandom);
            res   = $urandom;
            rr    = $urandom;
            m2r   = $urandom % 2;
            rw    = $urandom % 2;
            sz    = 2'($urandom);
            uns   = $urandom % 2;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
